// File: rtl/ram_access_ctrl_if.sv
// Bundle of the two requester ports and the RAM-wrapper port of ram_access_ctrl.
// Handshake: a requester holds req and its fields stable until gnt is high in the same cycle; rvalid follows one cycle after each gnt.
interface ram_access_ctrl_if #(parameter int ADDR_W = 32);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_signed;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_rden;
    logic [3:0]        ram_wren;
    logic [31:0]       ram_rdata;

    // Controller side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output ram_addr, ram_wdata, ram_rden, ram_wren
    );

    // Core pipeline and RAM wrapper side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_addr, ram_wdata, ram_rden, ram_wren
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Arbitrates fetch and load/store onto the single byte-lane RAM port and
// aligns/extends the read data in the cycle after each grant.
module ram_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int FAIR   = 1
) (
    input logic              m_clock,
    input logic              p_reset,
    ram_access_ctrl_if.slave bus
);
    localparam bit FAIR_EN = (FAIR != 0);

    logic       last_gnt_i;
    logic       gnt_i;
    logic       gnt_d;
    logic [1:0] d_off;
    logic       d_bad;
    logic [3:0] d_mask;
    logic [31:0] d_wrep;

    logic       rsp_valid;
    logic       rsp_is_d;
    logic       rsp_we;
    logic [1:0] rsp_size;
    logic       rsp_signed;
    logic [1:0] rsp_off;
    logic       rsp_err;
    logic       rsp_live;
    logic [31:0] shifted;

    // Data wins under contention when fairness is off or fetch had the last grant.
    assign gnt_d = !p_reset && bus.d_req && (!bus.i_req || !FAIR_EN || last_gnt_i);
    assign gnt_i = !p_reset && bus.i_req && !gnt_d;
    assign bus.i_gnt = gnt_i;
    assign bus.d_gnt = gnt_d;

    always_comb begin
        d_off  = bus.d_addr[1:0];
        d_bad  = 1'b0;
        d_mask = 4'b0000;
        d_wrep = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                d_mask = 4'b0001 << d_off;
                d_wrep = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                d_bad  = d_off[0];
                d_mask = d_off[1] ? 4'b1100 : 4'b0011;
                d_wrep = {2{bus.d_wdata[15:0]}};
            end
            2'b10: begin
                d_bad  = (d_off != 2'b00);
                d_mask = 4'b1111;
            end
            default: d_bad = 1'b1;
        endcase
        // Faulting accesses are granted and answered but never touch the RAM.
        if (d_bad) d_mask = 4'b0000;
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_rden  = 4'b0000;
        bus.ram_wren  = 4'b0000;
        if (gnt_i) begin
            bus.ram_addr = bus.i_addr;
            bus.ram_rden = 4'b1111;
        end else if (gnt_d) begin
            bus.ram_addr  = bus.d_addr;
            bus.ram_wdata = d_wrep;
            if (bus.d_we) bus.ram_wren = d_mask;
            else          bus.ram_rden = d_mask;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            last_gnt_i <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_is_d   <= 1'b0;
            rsp_we     <= 1'b0;
            rsp_size   <= 2'b00;
            rsp_signed <= 1'b0;
            rsp_off    <= 2'b00;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= gnt_i || gnt_d;
            if (gnt_i || gnt_d) begin
                last_gnt_i <= gnt_i;
                rsp_is_d   <= gnt_d;
                rsp_we     <= bus.d_we;
                rsp_size   <= bus.d_size;
                rsp_signed <= bus.d_signed;
                rsp_off    <= d_off;
                rsp_err    <= gnt_d && d_bad;
            end
        end
    end

    // A response pending when reset arrives is discarded, not delivered late.
    assign rsp_live     = rsp_valid && !p_reset;
    assign bus.i_rvalid = rsp_live && !rsp_is_d;
    assign bus.d_rvalid = rsp_live && rsp_is_d;
    assign bus.d_err    = bus.d_rvalid && rsp_err;
    assign bus.i_rdata  = bus.i_rvalid ? bus.ram_rdata : 32'h0;
    assign shifted      = bus.ram_rdata >> {rsp_off, 3'b000};

    always_comb begin
        bus.d_rdata = 32'h0;
        if (bus.d_rvalid && !rsp_err && !rsp_we) begin
            case (rsp_size)
                2'b00:   bus.d_rdata = {{24{rsp_signed && shifted[7]}}, shifted[7:0]};
                2'b01:   bus.d_rdata = {{16{rsp_signed && shifted[15]}}, shifted[15:0]};
                default: bus.d_rdata = shifted;
            endcase
        end
    end
endmodule
